// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: IFU and LSU request/response
// channels plus the shared single memory port.
interface mem_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_we;
    logic [2:0]  lsu_ctr;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_resp_valid;
    logic        lsu_resp_err;
    logic [31:0] lsu_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [2:0]  mem_ctr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_we, lsu_ctr, lsu_addr, lsu_wdata,
        output mem_rd,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_rdata,
        input  mem_en, mem_we, mem_ctr, mem_addr, mem_wd
    );

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_we, lsu_ctr, lsu_addr, lsu_wdata,
        input  mem_rd,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_rdata,
        output mem_en, mem_we, mem_ctr, mem_addr, mem_wd
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port
// between instruction fetch and load/store, one transaction at a time.
module mem_arbiter #(
    parameter int LATENCY = 1
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;
    localparam logic [2:0] CNT_INIT =
        (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        r_last;
    logic        r_owner;
    logic        r_err;
    logic [31:0] r_addr;
    logic [2:0]  r_ctr;
    logic [31:0] r_wd;

    logic w_legal;
    logic w_idle;
    logic w_resp;
    logic w_gnt_ifu;
    logic w_gnt_lsu;
    logic w_acc;

    assign w_legal = (bus.lsu_ctr == 3'b000) ||
                     (bus.lsu_ctr == 3'b001) ||
                     (bus.lsu_ctr == 3'b010) ||
                     (bus.lsu_ctr == 3'b100) ||
                     (bus.lsu_ctr == 3'b101);

    // Gating with rst_n keeps every output low while reset is held.
    assign w_idle = rst_n && (r_state == IDLE);
    assign w_resp = rst_n && (r_state == RESP);

    assign w_gnt_ifu = w_idle && bus.ifu_req_valid &&
                       (!bus.lsu_req_valid || r_last == OWN_LSU);
    assign w_gnt_lsu = w_idle && bus.lsu_req_valid &&
                       (!bus.ifu_req_valid || r_last == OWN_IFU);
    assign w_acc = w_gnt_ifu || w_gnt_lsu;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_acc) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_comb begin
        bus.ifu_req_ready = w_gnt_ifu;
        bus.lsu_req_ready = w_gnt_lsu;
        bus.mem_en   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = r_addr;
        bus.mem_ctr  = r_ctr;
        bus.mem_wd   = r_wd;
        unique case (1'b1)
            w_gnt_ifu: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.ifu_addr;
                bus.mem_ctr  = 3'b010;
                bus.mem_wd   = 32'd0;
            end
            w_gnt_lsu: begin
                bus.mem_en   = w_legal;
                bus.mem_we   = w_legal && bus.lsu_we;
                bus.mem_addr = bus.lsu_addr;
                bus.mem_ctr  = bus.lsu_ctr;
                bus.mem_wd   = bus.lsu_wdata;
            end
            default: begin
            end
        endcase

        bus.ifu_resp_valid = w_resp && (r_owner == OWN_IFU);
        bus.ifu_rdata = bus.ifu_resp_valid ? bus.mem_rd : 32'd0;
        bus.lsu_resp_valid = w_resp && (r_owner == OWN_LSU);
        bus.lsu_resp_err = bus.lsu_resp_valid && r_err;
        bus.lsu_rdata = (bus.lsu_resp_valid && !r_err) ?
                        bus.mem_rd : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_last  <= OWN_LSU;
            r_owner <= OWN_IFU;
            r_err   <= 1'b0;
            r_addr  <= 32'd0;
            r_ctr   <= 3'd0;
            r_wd    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_acc) begin
                r_owner <= w_gnt_lsu;
                r_last  <= w_gnt_lsu;
                r_err   <= w_gnt_lsu && !w_legal;
                r_addr  <= bus.mem_addr;
                r_ctr   <= bus.mem_ctr;
                r_wd    <= bus.mem_wd;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios and random traffic on
// LATENCY=1 and LATENCY=3 instances against a cycle-count model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int dsel = 0;
    int lat;
    logic rn = 1'b0;
    logic rn1, rn3;
    logic iv = 1'b0, lv = 1'b0, lwe = 1'b0;
    logic [2:0] lctr = 3'd0;
    logic [31:0] ia = '0, la = '0, lwd = '0, mrd = '0;

    mem_arbiter_if b1();
    mem_arbiter_if b3();

    mem_arbiter #(.LATENCY(1)) u1 (.clk(clk), .rst_n(rn1), .bus(b1.slave));
    mem_arbiter #(.LATENCY(3)) u3 (.clk(clk), .rst_n(rn3), .bus(b3.slave));

    // The idle instance is held in reset with quiet inputs.
    assign lat = (dsel == 0) ? 1 : 3;
    assign rn1 = (dsel == 0) ? rn : 1'b0;
    assign rn3 = (dsel == 1) ? rn : 1'b0;
    assign b1.ifu_req_valid = (dsel == 0) && iv;
    assign b3.ifu_req_valid = (dsel == 1) && iv;
    assign b1.lsu_req_valid = (dsel == 0) && lv;
    assign b3.lsu_req_valid = (dsel == 1) && lv;
    assign b1.ifu_addr = ia;
    assign b3.ifu_addr = ia;
    assign b1.lsu_we = lwe;
    assign b3.lsu_we = lwe;
    assign b1.lsu_ctr = lctr;
    assign b3.lsu_ctr = lctr;
    assign b1.lsu_addr = la;
    assign b3.lsu_addr = la;
    assign b1.lsu_wdata = lwd;
    assign b3.lsu_wdata = lwd;
    assign b1.mem_rd = mrd;
    assign b3.mem_rd = mrd;

    logic o_ir, o_lr, o_iv, o_lv, o_le, o_en, o_we;
    logic [2:0] o_ctr;
    logic [31:0] o_id, o_ld, o_addr, o_wd;
    always_comb begin
        if (dsel == 0) begin
            o_ir = b1.ifu_req_ready;  o_lr = b1.lsu_req_ready;
            o_iv = b1.ifu_resp_valid; o_id = b1.ifu_rdata;
            o_lv = b1.lsu_resp_valid; o_le = b1.lsu_resp_err;
            o_ld = b1.lsu_rdata;      o_en = b1.mem_en;
            o_we = b1.mem_we;         o_ctr = b1.mem_ctr;
            o_addr = b1.mem_addr;     o_wd = b1.mem_wd;
        end else begin
            o_ir = b3.ifu_req_ready;  o_lr = b3.lsu_req_ready;
            o_iv = b3.ifu_resp_valid; o_id = b3.ifu_rdata;
            o_lv = b3.lsu_resp_valid; o_le = b3.lsu_resp_err;
            o_ld = b3.lsu_rdata;      o_en = b3.mem_en;
            o_we = b3.mem_we;         o_ctr = b3.mem_ctr;
            o_addr = b3.mem_addr;     o_wd = b3.mem_wd;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    // Model: an open transaction is just its age in cycles since
    // acceptance; the response is due when the age reaches LATENCY.
    bit m_busy = 0;
    int m_age = 0;
    bit m_owner = 0;
    bit m_last = 1;
    bit m_err = 0;
    logic [31:0] m_addr = '0, m_wd = '0;
    logic [2:0] m_ctr = '0;
    bit acc_i = 0, acc_l = 0;
    int n_resp = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit gi, gl, legal, rsp;
        #1;
        acc_i = 0;
        acc_l = 0;
        if (!rn) begin
            chk("rst_ifu_ready", 32'(o_ir), 0);
            chk("rst_lsu_ready", 32'(o_lr), 0);
            chk("rst_ifu_rv", 32'(o_iv), 0);
            chk("rst_ifu_rdata", o_id, 0);
            chk("rst_lsu_rv", 32'(o_lv), 0);
            chk("rst_lsu_err", 32'(o_le), 0);
            chk("rst_lsu_rdata", o_ld, 0);
            chk("rst_mem_en", 32'(o_en), 0);
            chk("rst_mem_we", 32'(o_we), 0);
            chk("rst_mem_ctr", 32'(o_ctr), 0);
            chk("rst_mem_addr", o_addr, 0);
            chk("rst_mem_wd", o_wd, 0);
            m_busy = 0;
            m_last = 1;
        end else if (!m_busy) begin
            gi = iv && (!lv || m_last);
            gl = lv && (!iv || !m_last);
            legal = lctr inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            chk("ifu_ready", 32'(o_ir), 32'(gi));
            chk("lsu_ready", 32'(o_lr), 32'(gl));
            chk("idle_ifu_rv", 32'(o_iv), 0);
            chk("idle_ifu_rdata", o_id, 0);
            chk("idle_lsu_rv", 32'(o_lv), 0);
            chk("idle_lsu_err", 32'(o_le), 0);
            chk("idle_lsu_rdata", o_ld, 0);
            if (gi) begin
                chk("acc_i_en", 32'(o_en), 1);
                chk("acc_i_we", 32'(o_we), 0);
                chk("acc_i_addr", o_addr, ia);
                chk("acc_i_ctr", 32'(o_ctr), 32'd2);
                chk("acc_i_wd", o_wd, 0);
                m_owner = 0; m_err = 0;
                m_addr = ia; m_ctr = 3'b010; m_wd = '0;
            end else if (gl) begin
                chk("acc_l_en", 32'(o_en), 32'(legal));
                chk("acc_l_we", 32'(o_we), 32'(legal && lwe));
                chk("acc_l_addr", o_addr, la);
                chk("acc_l_ctr", 32'(o_ctr), 32'(lctr));
                chk("acc_l_wd", o_wd, lwd);
                m_owner = 1; m_err = !legal;
                m_addr = la; m_ctr = lctr; m_wd = lwd;
            end else begin
                chk("idle_en", 32'(o_en), 0);
                chk("idle_we", 32'(o_we), 0);
            end
            if (gi || gl) begin
                m_busy = 1;
                m_age = 0;
                m_last = m_owner;
            end
            acc_i = gi;
            acc_l = gl;
        end else begin
            m_age++;
            rsp = (m_age == lat);
            chk("busy_ifu_ready", 32'(o_ir), 0);
            chk("busy_lsu_ready", 32'(o_lr), 0);
            chk("busy_en", 32'(o_en), 0);
            chk("busy_we", 32'(o_we), 0);
            chk("hold_addr", o_addr, m_addr);
            chk("hold_ctr", 32'(o_ctr), 32'(m_ctr));
            chk("hold_wd", o_wd, m_wd);
            chk("ifu_rv", 32'(o_iv), 32'(rsp && !m_owner));
            chk("ifu_rdata", o_id, (rsp && !m_owner) ? mrd : 32'd0);
            chk("lsu_rv", 32'(o_lv), 32'(rsp && m_owner));
            chk("lsu_err", 32'(o_le), 32'(rsp && m_owner && m_err));
            chk("lsu_rdata", o_ld,
                (rsp && m_owner && !m_err) ? mrd : 32'd0);
            if (rsp) begin
                m_busy = 0;
                n_resp++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (acc_i || !iv) begin
                iv = 1'($urandom_range(0, 1));
                ia = $urandom;
            end
            if (acc_l || !lv) begin
                lv = 1'($urandom_range(0, 1));
                lwe = 1'($urandom_range(0, 1));
                lctr = 3'($urandom_range(0, 7));
                la = $urandom;
                lwd = $urandom;
            end
            mrd = $urandom;
            rn = ($urandom_range(0, 59) != 0);
            tick();
        end
        rn = 1'b1;
        iv = 1'b0;
        lv = 1'b0;
        for (int c = 0; c < 6; c++) tick();
    endtask

    initial begin
        int r0;
        logic [3:0] gseq;
        @(posedge clk);
        #1;

        // LATENCY=1 instance
        dsel = 0;
        rn = 0;
        tick();
        tick();
        rn = 1;
        iv = 1;
        ia = 32'h8000_0000;
        mrd = 32'h0000_0413;
        tick();
        iv = 0;
        chk("l1_resp_rv", 32'(o_iv), 1);
        chk("l1_resp_rdata", o_id, 32'h0000_0413);
        tick();
        tick();

        rn = 0;
        tick();
        rn = 1;
        iv = 1;
        lv = 1;
        lwe = 0;
        lctr = 3'b010;
        la = 32'h8000_2000;
        ia = 32'h8000_0004;
        gseq = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            gseq[k] = acc_l;
            tick();
        end
        chk("rr_alternation", 32'(gseq), 32'b1010);
        iv = 0;
        lv = 0;
        tick();
        rand_run(400);

        // LATENCY=3 instance
        dsel = 1;
        rn = 0;
        tick();
        rn = 1;
        tick();
        lv = 1;
        lwe = 1;
        lctr = 3'b000;
        la = 32'h8000_1003;
        lwd = 32'h0000_00AB;
        tick();
        lv = 0;
        for (int k = 0; k < 4; k++) tick();

        r0 = n_resp;
        lv = 1;
        lwe = 0;
        lctr = 3'b011;
        mrd = 32'hDEAD_BEEF;
        tick();
        lv = 0;
        for (int k = 0; k < 3; k++) tick();
        chk("err_resp_seen", 32'(n_resp - r0), 1);

        r0 = n_resp;
        iv = 1;
        ia = 32'h8000_0100;
        tick();
        iv = 0;
        lv = 1;
        lctr = 3'b010;
        la = 32'h8000_0200;
        rn = 0;
        tick();
        rn = 1;
        tick();
        chk("post_rst_lsu_acc", 32'(acc_l), 1);
        lv = 0;
        for (int k = 0; k < 4; k++) tick();
        chk("post_rst_one_resp", 32'(n_resp - r0), 1);
        rand_run(400);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL expose parameter LATENCY, default 1: memory-port read latency in cycles, from issue edge to mem_rd valid; legal range 1..7.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports ifu_req_valid in 1, ifu_req_ready out 1, ifu_addr in 32: instruction-fetch request, always a 4-byte read.
REQ-005 SHALL have ports ifu_resp_valid out 1, ifu_rdata out 32: instruction-fetch response.
REQ-006 SHALL have ports lsu_req_valid in 1, lsu_req_ready out 1, lsu_we in 1, lsu_ctr in 3, lsu_addr in 32, lsu_wdata in 32: load/store request.
REQ-007 SHALL encode lsu_ctr as 000 byte-signed, 001 half-signed, 010 word, 100 byte-unsigned, 101 half-unsigned; 011/110/111 are illegal.
REQ-008 SHALL have ports lsu_resp_valid out 1, lsu_resp_err out 1, lsu_rdata out 32: load/store response.
REQ-009 SHALL have ports mem_en out 1, mem_we out 1, mem_ctr out 3, mem_addr out 32, mem_wd out 32, mem_rd in 32: the shared single memory port.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-011 In IDLE, a request SHALL be accepted in the cycle where its valid and ready are both high; at most one is accepted per cycle.
REQ-012 Tie-break when both valid in IDLE SHALL be round-robin via register last_grant: the requester not granted last wins.
REQ-013 When only one valid in IDLE, that requester SHALL be granted regardless of last_grant.
REQ-014 ready SHALL be combinational, high only in IDLE and only toward the granted requester; both ready SHALL be low in WAIT and RESP.
REQ-015 In the accept cycle, mem_en SHALL be 1 and mem_addr/mem_ctr/mem_wd/mem_we SHALL be driven combinationally from the winner; IFU forces mem_ctr=010, mem_we=0, mem_wd=0.
REQ-016 At the accept edge, the block SHALL latch owner, addr, ctr, wdata, we; last_grant SHALL update to owner.
REQ-017 In WAIT and RESP, mem_en and mem_we SHALL be 0; mem_addr/mem_ctr/mem_wd SHALL hold latched values.
REQ-018 After accept, LATENCY=1 SHALL go IDLE->RESP; LATENCY>1 SHALL go IDLE->WAIT, hold WAIT for LATENCY-1 cycles via down-counter, then go to RESP.
REQ-019 RESP SHALL last exactly one cycle and return to IDLE; response cycle = accept cycle + LATENCY; no accept in RESP.
REQ-020 In RESP, the owner's resp_valid SHALL pulse high for one cycle and its rdata SHALL equal mem_rd combinationally; the other requester's resp_valid SHALL stay 0.
REQ-021 Store requests SHALL also receive a response pulse; lsu_rdata then carries mem_rd (don't-care to the LSU).
REQ-022 An illegal lsu_ctr SHALL still be accepted but issue mem_en=0 and mem_we=0, follow the normal timing, and respond with lsu_resp_err=1 and lsu_rdata=0.
REQ-023 lsu_resp_err SHALL be 0 outside an error response cycle.
REQ-024 Outside RESP, ifu_rdata and lsu_rdata SHALL be 0.
REQ-025 Throughput SHALL be one transaction per LATENCY+1 cycles; a requester held valid across RESP SHALL be arbitrated in the following IDLE cycle.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counter 0, last_grant=LSU (so IFU wins the first tie), and latched fields 0.
REQ-027 During reset, all outputs SHALL be 0, including ready, resp_valid, resp_err, rdata, and all mem_* outputs.
REQ-028 Reset asserted mid-transaction SHALL drop the transaction with no response pulse; the first IDLE cycle after release SHALL arbitrate afresh.

Verification
REQ-029 LATENCY=1; IFU-only read of addr 0x80000000, mem_rd=0x00000413 -> mem_en=1 at T, ifu_resp_valid=1 and ifu_rdata=0x00000413 at T+1, IDLE at T+2.
REQ-030 Both valid from reset -> IFU granted first, LSU granted at T+2; both held valid -> grants alternate IFU, LSU, IFU.
REQ-031 LATENCY=3; LSU store sb: ctr=000, addr=0x80001003, wd=0xAB -> mem_we=1 for exactly one cycle at T; lsu_resp_valid at T+3; mem_addr holds 0x80001003 during T+1..T+3.
REQ-032 LSU ctr=011 -> mem_en=0 throughout; lsu_resp_valid=1, lsu_resp_err=1, lsu_rdata=0 at T+LATENCY.
REQ-033 LATENCY=3; rst_n low at T+1 of an IFU read -> outputs 0 immediately; no ifu_resp_valid; after release, a pending LSU request is accepted in the first cycle.
